// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch buffer between the fetch and decode stages.
package fetch_pkg;

   localparam int          FB_WIDTH  = 32;
   localparam int          FB_DEPTH  = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [FB_WIDTH-1:0] instr;
      logic [FB_WIDTH-1:0] pc;
      logic [FB_WIDTH-1:0] pc_plus4;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO decoupling instruction fetch from decode, cleared on branch redirect.
// Optional FETCH_BUFFER_NOP_EN forces out_instr to a NOP whenever no valid head is presented.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = FB_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_instr,
   input  logic [WIDTH-1:0]         in_pc,
   input  logic [WIDTH-1:0]         in_pc_plus4,
   output logic                     in_ready,
   input  logic                     flush,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_instr,
   output logic [WIDTH-1:0]         out_pc,
   output logic [WIDTH-1:0]         out_pc_plus4,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     head;
   fetch_entry_t     wr_entry;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push;
   logic             pop;

   // No bypass in either direction: a full buffer never accepts, an empty one never presents.
   assign in_ready  = (count_q < CNT_W'(DEPTH));
   assign out_valid = (count_q != '0) && !flush;
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready;
   assign count     = count_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_entry.instr    = FB_WIDTH'(in_instr);
   assign wr_entry.pc       = FB_WIDTH'(in_pc);
   assign wr_entry.pc_plus4 = FB_WIDTH'(in_pc_plus4);

   // Storage is deliberately left out of reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_entry;
   end

   assign head         = mem_q[rd_ptr_q];
   assign out_pc       = WIDTH'(head.pc);
   assign out_pc_plus4 = WIDTH'(head.pc_plus4);

`ifdef FETCH_BUFFER_NOP_EN
   assign out_instr = out_valid ? WIDTH'(head.instr) : WIDTH'(NOP_INSTR);
`else
   assign out_instr = WIDTH'(head.instr);
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_buffer;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              inValid;
   logic [WIDTH-1:0]  inInstr;
   logic [WIDTH-1:0]  inPc;
   logic [WIDTH-1:0]  inPc4;
   logic              inReady;
   logic              flush;
   logic              outValid;
   logic [WIDTH-1:0]  outInstr;
   logic [WIDTH-1:0]  outPc;
   logic [WIDTH-1:0]  outPc4;
   logic              outReady;
   logic [2:0]        count;

   typedef struct {
      logic [WIDTH-1:0] instr;
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] pc4;
   } entryT;

   entryT modelQ[$];
   entryT modelMem[DEPTH];
   bit    memWritten[DEPTH];
   int    wrIdx;
   int    rdIdx;
   int    errors = 0;
   int    checks = 0;

   fetch_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (inValid),
      .in_instr     (inInstr),
      .in_pc        (inPc),
      .in_pc_plus4  (inPc4),
      .in_ready     (inReady),
      .flush        (flush),
      .out_valid    (outValid),
      .out_instr    (outInstr),
      .out_pc       (outPc),
      .out_pc_plus4 (outPc4),
      .out_ready    (outReady),
      .count        (count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] pc, input logic rdy, input logic fl);
      inValid  = v;
      inPc     = pc;
      inPc4    = pc + 32'd4;
      inInstr  = $urandom;
      outReady = rdy;
      flush    = fl;
      #1;
   endtask

   task automatic modelReset();
      modelQ.delete();
      wrIdx = 0;
      rdIdx = 0;
   endtask

   // Advance one clock; the model follows the behavioural rules for push, pop and flush.
   task automatic tick();
      bit    doPush;
      bit    doPop;
      entryT e;
      doPush = inValid && (modelQ.size() < DEPTH) && !flush;
      doPop  = (modelQ.size() != 0) && !flush && outReady;
      e      = '{inInstr, inPc, inPc4};
      @(posedge clk);
      if (flush) begin
         modelReset();
      end else begin
         if (doPop) begin
            void'(modelQ.pop_front());
            rdIdx = (rdIdx + 1) % DEPTH;
         end
         if (doPush) begin
            modelQ.push_back(e);
            modelMem[wrIdx]   = e;
            memWritten[wrIdx] = 1'b1;
            wrIdx = (wrIdx + 1) % DEPTH;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      #12;
      checks++;
      if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
      checks++;
      if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid); end
      checks++;
      if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", inReady); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      modelReset();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'(i * 4), 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (count !== 3'd3) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 3", count); end
      checks++;
      if (outPc !== 32'h0) begin errors++; $display("[TB] FAIL fill_out_pc: got %h expected 0", outPc); end
      checks++;
      if (outPc4 !== 32'h4) begin errors++; $display("[TB] FAIL fill_out_pc4: got %h expected 4", outPc4); end
      checks++;
      if (outInstr !== modelQ[0].instr) begin errors++; $display("[TB] FAIL fill_out_instr: got %h expected %h", outInstr, modelQ[0].instr); end
      checks++;
      if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL fill_in_ready: got %b expected 1", inReady); end
      checks++;
      if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL fill_out_valid: got %b expected 1", outValid); end
   endtask

   task automatic test_full();
      applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
      checks++;
      if (count !== 3'd4) begin errors++; $display("[TB] FAIL full_count: got %0d expected 4", count); end
      checks++;
      if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got %b expected 0", inReady); end
      tick();
      applyStimulus(1'b1, 32'h14, 1'b1, 1'b0);
      checks++;
      if (count !== 3'd4) begin errors++; $display("[TB] FAIL full_ignore_count: got %0d expected 4", count); end
      checks++;
      if (outPc !== 32'h0) begin errors++; $display("[TB] FAIL full_head_pc: got %h expected 0", outPc); end
      tick();
      checks++;
      if (count !== 3'd3) begin errors++; $display("[TB] FAIL full_pop_no_push: got %0d expected 3", count); end
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0);
         checks++;
         if (outPc !== 32'(i * 4)) begin errors++; $display("[TB] FAIL full_drain_pc: got %h expected %h", outPc, 32'(i * 4)); end
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL full_drained_valid: got %b expected 0", outValid); end
      checks++;
      if (count !== 3'd0) begin errors++; $display("[TB] FAIL full_drained_count: got %0d expected 0", count); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i <= 10; i++) begin
         applyStimulus(i < 10, 32'(i * 4), 1'b1, 1'b0);
         if (i > 0) begin
            checks++;
            if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid: got %b expected 1", outValid); end
            checks++;
            if (outPc !== 32'((i - 1) * 4)) begin errors++; $display("[TB] FAIL b2b_pc: got %h expected %h", outPc, 32'((i - 1) * 4)); end
            checks++;
            if (count !== 3'd1) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 1", count); end
         end
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (count !== 3'd0) begin errors++; $display("[TB] FAIL b2b_final_count: got %0d expected 0", count); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
      checks++;
      if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid: got %b expected 0", outValid); end
      checks++;
      if (count !== 3'd3) begin errors++; $display("[TB] FAIL flush_pre_count: got %0d expected 3", count); end
      tick();
      applyStimulus(1'b1, 32'h300, 1'b0, 1'b0);
      checks++;
      if (count !== 3'd0) begin errors++; $display("[TB] FAIL flush_count: got %0d expected 0", count); end
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (outPc !== 32'h300) begin errors++; $display("[TB] FAIL flush_next_pc: got %h expected 300", outPc); end
      checks++;
      if (count !== 3'd1) begin errors++; $display("[TB] FAIL flush_next_count: got %0d expected 1", count); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 8 && modelQ.size() != 0; i++) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0);
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (count !== 3'd2) begin errors++; $display("[TB] FAIL areset_pre_count: got %0d expected 2", count); end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (count !== 3'd0) begin errors++; $display("[TB] FAIL areset_count: got %0d expected 0", count); end
      checks++;
      if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL areset_out_valid: got %b expected 0", outValid); end
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      modelReset();
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (outPc !== 32'h40) begin errors++; $display("[TB] FAIL areset_next_pc: got %h expected 40", outPc); end
      checks++;
      if (count !== 3'd1) begin errors++; $display("[TB] FAIL areset_next_count: got %0d expected 1", count); end
   endtask

   task automatic test_stale();
      logic [WIDTH-1:0] expInstr;
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL stale_valid: got %b expected 0", outValid); end
      if (memWritten[rdIdx]) begin
         expInstr = modelMem[rdIdx].instr;
`ifdef FETCH_BUFFER_NOP_EN
         expInstr = 32'h0000_0013;
`endif
         checks++;
         if (outInstr !== expInstr) begin errors++; $display("[TB] FAIL stale_instr: got %h expected %h", outInstr, expInstr); end
         checks++;
         if (outPc !== modelMem[rdIdx].pc) begin errors++; $display("[TB] FAIL stale_pc: got %h expected %h", outPc, modelMem[rdIdx].pc); end
      end
   endtask

   task automatic test_random();
      bit               expValid;
      bit               hasExp;
      logic [WIDTH-1:0] expInstr;
      for (int n = 0; n < 400; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 15) == 0));
         expValid = (modelQ.size() != 0) && !flush;
         checks++;
         if (int'(count) !== modelQ.size()) begin errors++; $display("[TB] FAIL rnd_count: got %0d expected %0d", count, modelQ.size()); end
         checks++;
         if (inReady !== (modelQ.size() < DEPTH)) begin errors++; $display("[TB] FAIL rnd_in_ready: got %b expected %b", inReady, modelQ.size() < DEPTH); end
         checks++;
         if (outValid !== expValid) begin errors++; $display("[TB] FAIL rnd_out_valid: got %b expected %b", outValid, expValid); end
         if (modelQ.size() != 0) begin
            checks++;
            if (outPc !== modelQ[0].pc || outPc4 !== modelQ[0].pc4) begin
               errors++;
               $display("[TB] FAIL rnd_head_pc: got %h/%h expected %h/%h", outPc, outPc4, modelQ[0].pc, modelQ[0].pc4);
            end
         end
         hasExp   = (modelQ.size() != 0) || memWritten[rdIdx];
         expInstr = (modelQ.size() != 0) ? modelQ[0].instr : modelMem[rdIdx].instr;
`ifdef FETCH_BUFFER_NOP_EN
         if (!expValid) begin
            expInstr = 32'h0000_0013;
            hasExp   = 1'b1;
         end
`endif
         if (hasExp) begin
            checks++;
            if (outInstr !== expInstr) begin errors++; $display("[TB] FAIL rnd_instr: got %h expected %h", outInstr, expInstr); end
         end
         tick();
      end
   endtask

   initial begin
      rst      = 1'b1;
      inValid  = 1'b0;
      inInstr  = '0;
      inPc     = '0;
      inPc4    = '0;
      outReady = 1'b0;
      flush    = 1'b0;
      modelReset();
      test_reset();
      test_fill();
      test_full();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_stale();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: instruction/address width.
REQ-002 SHALL have parameter DEPTH, default 4: entry count; power of two, >=2.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  fetch stage presents an entry.
REQ-006 SHALL have port in_instr  input  WIDTH  fetched instruction word.
REQ-007 SHALL have port in_pc  input  WIDTH  PC of that instruction.
REQ-008 SHALL have port in_pc_plus4  input  WIDTH  return address (PC+4).
REQ-009 SHALL have port in_ready  output  1  buffer accepts entry; drives PC register enable.
REQ-010 SHALL have port flush  input  1  taken branch/jump redirect (PCsrc); discard contents.
REQ-011 SHALL have port out_valid  output  1  head entry valid for decode.
REQ-012 SHALL have ports out_instr, out_pc, out_pc_plus4  output  WIDTH each  head entry fields.
REQ-013 SHALL have port out_ready  input  1  decode accepts head (not stalled).
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-015 SHALL push when in_valid && in_ready && !flush; entry written at rd/wr pointer wr_ptr, wr_ptr increments modulo DEPTH.
REQ-016 SHALL pop when out_valid && out_ready; rd_ptr increments modulo DEPTH.
REQ-017 SHALL drive in_ready = (count < DEPTH); no full-bypass: when full, a same-cycle pop does not allow a push.
REQ-018 SHALL drive out_valid = (count != 0) && !flush; no empty-bypass: pushed entry visible from cycle after push edge (latency 1).
REQ-019 SHALL read head fields combinationally from storage at rd_ptr.
REQ-020 SHALL on simultaneous push and pop (not full, not empty) keep count unchanged, advance both pointers.
REQ-021 SHALL on flush at a clock edge set count=0, rd_ptr=wr_ptr=0; push and pop in that cycle ignored.
REQ-022 SHALL preserve FIFO order across pointer wrap-around.
REQ-023 SHALL ignore in_valid when full; upstream holds entry (in_ready=0 stalls PC).

Reset
REQ-024 SHALL on rst asserted asynchronously set count=0, rd_ptr=0, wr_ptr=0, out_valid=0, in_ready=1; storage contents not reset.
REQ-025 SHALL on rst asserted mid-operation drop all entries; first push after deassertion lands in entry 0.

Configuration
REQ-026 SHALL honour macro FETCH_BUFFER_NOP_EN: when defined, out_instr = 32'h00000013 (addi x0,x0,0) whenever out_valid=0; out_pc/out_pc_plus4 unaffected.
REQ-027 SHALL without FETCH_BUFFER_NOP_EN drive out_instr from storage at rd_ptr unconditionally.

Structure
REQ-028 SHALL place in shared package fetch_pkg: typedef fetch_entry_t (instr, pc, pc_plus4), constant NOP_INSTR = 32'h00000013, default FB_DEPTH = 4.
REQ-029 SHALL be a single module; no sub-module; storage is an array of fetch_entry_t.

Verification
REQ-030 Reset then push pc=0x0,0x4,0x8 with out_ready=0 -> count=3, out_pc=0x0, in_ready=1.
REQ-031 Push 4 entries, out_ready=0 -> count=4, in_ready=0; 5th in_valid ignored; pop+push same cycle while full -> count=3 next, no push.
REQ-032 Continuous push/pop 10 entries pc 0x0..0x24, DEPTH=4 -> outputs in order across wrap, count steady 1.
REQ-033 count=3, assert flush with in_valid=1, out_ready=1 -> out_valid=0 that cycle; next cycle count=0, pointers 0.
REQ-034 Assert rst asynchronously between edges with count=2 -> count=0, out_valid=0 immediately; next push pc=0x40 appears as out_pc=0x40.
REQ-035 With FETCH_BUFFER_NOP_EN, buffer empty -> out_instr=0x00000013; without macro -> out_instr equals stale storage word.
